// File: rtl/throw_hit_sequencer.sv
`default_nettype none
// ==========================================================================
// throw_hit_sequencer : debounced start, ball-triggered bat swing sequencer
// Rev 1.0
// ==========================================================================
module throw_hit_sequencer #(
  parameter int DEB_CYC    = 1_000_000,
  parameter int THROW_CYC  = 50_000_000,
  parameter int WAIT_CYC   = 200_000_000,
  parameter int SWING_CYC  = 20_000_000,
  parameter int BRAKE_CYC  = 5_000_000,
  parameter int RETURN_CYC = 21_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       ball_sense,
  input  logic       abort,
  output logic [1:0] hitmode,
  output logic       throw,
  output logic       busy,
  output logic [2:0] state,
  output logic [7:0] hit_count,
  output logic       miss
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_THROW  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SWING  = 3'd3;
  localparam logic [2:0] S_BRAKE  = 3'd4;
  localparam logic [2:0] S_RETURN = 3'd5;

  localparam int M1   = (THROW_CYC > WAIT_CYC) ? THROW_CYC : WAIT_CYC;
  localparam int M2   = (SWING_CYC > BRAKE_CYC) ? SWING_CYC : BRAKE_CYC;
  localparam int M3   = (M1 > M2) ? M1 : M2;
  localparam int MAXC = (M3 > RETURN_CYC) ? M3 : RETURN_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int DW   = $clog2(DEB_CYC + 1);

  logic          r_btn_meta, r_btn_sync;
  logic          r_ball_meta, r_ball_sync, r_ball_prev;
  logic [DW-1:0] r_deb_cnt;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_hitmode;
  logic          r_throw, r_busy, r_miss;
  logic [7:0]    r_hit_count;

  logic [2:0]    w_next;
  logic          w_miss;
  logic          w_press, w_ball_evt, w_exp;
  logic [CW-1:0] w_limit;
  logic [1:0]    w_hitmode;
  logic          w_throw, w_busy, w_hit_inc;

  // Input synchronizers, debounce counter and ball edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_meta  <= 1'b0;
      r_btn_sync  <= 1'b0;
      r_ball_meta <= 1'b0;
      r_ball_sync <= 1'b0;
      r_ball_prev <= 1'b0;
      r_deb_cnt   <= '0;
    end else begin
      r_btn_meta  <= start_btn;
      r_btn_sync  <= r_btn_meta;
      r_ball_meta <= ball_sense;
      r_ball_sync <= r_ball_meta;
      r_ball_prev <= r_ball_sync;
      if (!r_btn_sync) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt != DW'(DEB_CYC)) begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  // Count saturates at DEB_CYC, so only the step onto it yields a press
  assign w_press    = r_btn_sync && (r_deb_cnt == DW'(DEB_CYC - 1));
  assign w_ball_evt = r_ball_sync && !r_ball_prev;

  always_comb begin
    w_limit = '0;
    case (r_state)
      S_THROW:  w_limit = CW'(THROW_CYC - 1);
      S_WAIT:   w_limit = CW'(WAIT_CYC - 1);
      S_SWING:  w_limit = CW'(SWING_CYC - 1);
      S_BRAKE:  w_limit = CW'(BRAKE_CYC - 1);
      S_RETURN: w_limit = CW'(RETURN_CYC - 1);
      default:  w_limit = '0;
    endcase
  end

  assign w_exp = (r_cnt == w_limit);

  // State register and state-time counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || (r_state == S_IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Next-state logic; abort outranks ball events and expiry
  always_comb begin
    w_next = r_state;
    w_miss = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) w_next = S_THROW;
      end
      S_THROW: begin
        if (abort)      w_next = S_IDLE;
        else if (w_exp) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (abort)           w_next = S_IDLE;
        else if (w_ball_evt) w_next = S_SWING;
        else if (w_exp) begin
          w_next = S_IDLE;
          w_miss = 1'b1;
        end
      end
      S_SWING: begin
        if (abort)      w_next = S_RETURN;
        else if (w_exp) w_next = S_BRAKE;
      end
      S_BRAKE: begin
        if (abort || w_exp) w_next = S_RETURN;
      end
      S_RETURN: begin
        if (w_exp) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs track the state
  always_comb begin
    w_hitmode = 2'd0;
    w_throw   = 1'b0;
    w_busy    = (w_next != S_IDLE);
    w_hit_inc = (w_next == S_SWING) && (r_state != S_SWING);
    case (w_next)
      S_THROW:  w_throw   = 1'b1;
      S_SWING:  w_hitmode = 2'd1;
      S_BRAKE:  w_hitmode = 2'd2;
      S_RETURN: w_hitmode = 2'd3;
      default:  w_hitmode = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hitmode   <= 2'd0;
      r_throw     <= 1'b0;
      r_busy      <= 1'b0;
      r_miss      <= 1'b0;
      r_hit_count <= 8'd0;
    end else begin
      r_hitmode <= w_hitmode;
      r_throw   <= w_throw;
      r_busy    <= w_busy;
      r_miss    <= w_miss;
      if (w_hit_inc && (r_hit_count != 8'hFF)) begin
        r_hit_count <= r_hit_count + 8'd1;
      end
    end
  end

  assign hitmode   = r_hitmode;
  assign throw     = r_throw;
  assign busy      = r_busy;
  assign state     = r_state;
  assign hit_count = r_hit_count;
  assign miss      = r_miss;

endmodule
`default_nettype wire

// File: doc/throw_hit_sequencer.md
THROW_HIT_SEQUENCER -- requirements
Module: throw_hit_sequencer

Interface
REQ-001 The block SHALL have parameter DEB_CYC, default 1_000_000, the number of clk cycles start_btn must be stable high to register a press.
REQ-002 The block SHALL have parameter THROW_CYC, default 50_000_000, the THROW state duration in cycles.
REQ-003 The block SHALL have parameter WAIT_CYC, default 200_000_000, the WAIT_BALL timeout in cycles.
REQ-004 The block SHALL have parameters SWING_CYC (default 20_000_000), BRAKE_CYC (default 5_000_000) and RETURN_CYC (default 21_000_000), the durations of the respective states; every *_CYC parameter SHALL be at least 1.
REQ-005 The block SHALL have port clk, input, 1 bit, the 100 MHz system clock.
REQ-006 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-007 The block SHALL have port start_btn, input, 1 bit, a raw asynchronous push-button.
REQ-008 The block SHALL have port ball_sense, input, 1 bit, a raw asynchronous IR ball sensor that is high when a ball is present.
REQ-009 The block SHALL have port abort, input, 1 bit, a synchronous level abort request.
REQ-010 The block SHALL have port hitmode, output, 2 bits, the bat-motor command to the motor stage: 0 = stop, 1 = swing, 2 = brake, 3 = return.
REQ-011 The block SHALL have port throw, output, 1 bit, the throw-motor enable to the motor stage.
REQ-012 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-013 The block SHALL have port state, output, 3 bits, the current FSM encoding.
REQ-014 The block SHALL have port hit_count, output, 8 bits, the number of swings started.
REQ-015 The block SHALL have port miss, output, 1 bit, a one-cycle pulse on WAIT_BALL timeout.

Function
REQ-016 start_btn and ball_sense SHALL each pass through a 2-flop synchronizer before use.
REQ-017 Debounce SHALL count consecutive synchronized-high cycles, clear the count on any low cycle, and emit exactly one press pulse when the count reaches DEB_CYC; no further pulse SHALL occur until the synchronized input has been low for at least one cycle.
REQ-018 A ball event SHALL be a rising edge of synchronized ball_sense (low on the previous cycle, high on the current cycle).
REQ-019 The FSM states SHALL be IDLE=0, THROW=1, WAIT_BALL=2, SWING=3, BRAKE=4, RETURN=5; codes 6 and 7 SHALL transition to IDLE on the next cycle.
REQ-020 One cycle counter SHALL be cleared on every state entry; a timed state SHALL exit when counter equals its *_CYC minus 1, so it occupies exactly *_CYC cycles.
REQ-021 IDLE SHALL go to THROW on a press pulse; all other states SHALL ignore press pulses.
REQ-022 THROW SHALL go to WAIT_BALL on expiry.
REQ-023 WAIT_BALL SHALL go to SWING on a ball event and SHALL go to IDLE with miss=1 for one cycle on expiry; if both occur in the same cycle, the ball event SHALL win and no miss pulse SHALL be issued.
REQ-024 SWING SHALL go to BRAKE on expiry, BRAKE SHALL go to RETURN on expiry, and RETURN SHALL go to IDLE on expiry.
REQ-025 While abort=1, THROW and WAIT_BALL SHALL go to IDLE next cycle; SWING and BRAKE SHALL go to RETURN next cycle with a freshly cleared counter; RETURN and IDLE SHALL be unaffected; abort SHALL take precedence over expiry and ball events.
REQ-026 Outputs SHALL be registered, decoded from the next-state value so that they change in the same cycle the state changes.
REQ-027 The output mapping SHALL be: throw=1 only in THROW; hitmode=1 in SWING, 2 in BRAKE, 3 in RETURN, and 0 otherwise.
REQ-028 hit_count SHALL increment by 1 on each entry to SWING and SHALL saturate at 255.
REQ-029 miss SHALL never be asserted outside the WAIT_BALL-to-IDLE transition.

Reset
REQ-030 On rst=1 the block SHALL asynchronously force state=IDLE, hitmode=0, throw=0, busy=0, miss=0 and hit_count=0, and SHALL clear all counters and synchronizer and edge flops.
REQ-031 Reset asserted mid-SWING SHALL drop hitmode to 0 immediately, with no return phase.
REQ-032 After rst deasserts, a press SHALL require a full DEB_CYC of stable-high input.

Verification (sim parameters: DEB_CYC=4, THROW_CYC=10, WAIT_CYC=20, SWING_CYC=6, BRAKE_CYC=2, RETURN_CYC=7)
REQ-033 Hold start_btn high for 3 cycles, then low -> no press pulse and state stays 0; hold it high for 20 cycles -> exactly one THROW entry.
REQ-034 Full cycle: press, then a ball edge 5 cycles into WAIT_BALL -> throw high for exactly 10 cycles, then hitmode reads 1 for 6 cycles, 2 for 2 cycles, 3 for 7 cycles, then 0; hit_count=1 and busy returns to 0.
REQ-035 Press with no ball -> WAIT_BALL lasts 20 cycles, miss pulses once, state returns to 0, and hit_count is unchanged.
REQ-036 A ball edge in the final WAIT_BALL cycle -> SWING is entered and miss stays 0.
REQ-037 abort asserted in cycle 3 of SWING -> hitmode=3 on the next cycle for 7 cycles, then 0; abort asserted during THROW -> throw=0 next cycle and state returns to 0.
REQ-038 Perform 256 full cycles -> hit_count holds at 255; rst asserted mid-BRAKE -> all outputs read 0 immediately.
